// File: rtl/apb_master_ctrl_if.sv
// apb_master_ctrl_if: processor request bus and APB master bus of apb_master_ctrl.
// The master modport is the bridge's view; the slave modport is the view of
// whatever sits on the other side (processor and APB slaves together).
interface apb_master_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int SEL_W  = 2
);
  // Processor side
  logic              p_start;
  logic              p_write;
  logic [SEL_W-1:0]  p_sel;
  logic [ADDR_W-1:0] p_addr;
  logic [DATA_W-1:0] p_wdata;
  logic [DATA_W-1:0] p_rdata;
  logic              p_stable;
  logic              p_error;
  // APB side
  logic [SEL_W-1:0]  psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              preset_n;
  // Debug
  logic [2:0]        state;

  modport master (
    input  p_start, p_write, p_sel, p_addr, p_wdata, prdata, pready,
    output p_rdata, p_stable, p_error, psel, penable, pwrite, paddr, pwdata,
           preset_n, state
  );

  modport slave (
    output p_start, p_write, p_sel, p_addr, p_wdata, prdata, pready,
    input  p_rdata, p_stable, p_error, psel, penable, pwrite, paddr, pwdata,
           preset_n, state
  );
endinterface

// File: rtl/apb_master_ctrl.sv
// apb_master_ctrl: single APB (v2-style) master bridging a one-shot processor
// request bus. IDLE -> SETUP (one cycle) -> ACCESS (until pready) -> IDLE.
// All outputs are registered. Optional build macro APB_TIMEOUT_EN adds a
// wait-state limit of MAX_WAIT cycles that aborts the transfer with p_error.
module apb_master_ctrl #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int SEL_W    = 2,
  parameter int MAX_WAIT = 16
) (
  input logic               clk,
  input logic               reset,
  apb_master_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_ACCESS = 3'd2
  } state_e;

  state_e            state_q,    state_d;
  logic [SEL_W-1:0]  psel_q,     psel_d;
  logic              penable_q,  penable_d;
  logic              pwrite_q,   pwrite_d;
  logic [ADDR_W-1:0] paddr_q,    paddr_d;
  logic [DATA_W-1:0] pwdata_q,   pwdata_d;
  logic [DATA_W-1:0] p_rdata_q,  p_rdata_d;
  logic              p_stable_q, p_stable_d;
  logic              p_error_q,  p_error_d;
  logic              preset_n_q;

`ifdef APB_TIMEOUT_EN
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  // Counter value at the edge that would be the MAX_WAIT-th wait state.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
`else
  // Keeps MAX_WAIT referenced when the timeout is compiled out.
  localparam int max_wait_unused = MAX_WAIT;
`endif

  // Next-state and registered-output computation for the transfer FSM.
  always_comb begin
    state_d    = state_q;
    psel_d     = psel_q;
    penable_d  = penable_q;
    pwrite_d   = pwrite_q;
    paddr_d    = paddr_q;
    pwdata_d   = pwdata_q;
    p_rdata_d  = p_rdata_q;
    p_stable_d = 1'b0;
    p_error_d  = 1'b0;
`ifdef APB_TIMEOUT_EN
    wait_cnt_d = '0;
`endif
    case (state_q)
      ST_IDLE: begin
        psel_d    = '0;
        penable_d = 1'b0;
        if (bus.p_start && (bus.p_sel != '0)) begin
          state_d  = ST_SETUP;
          psel_d   = bus.p_sel;
          pwrite_d = bus.p_write;
          paddr_d  = bus.p_addr;
          // Reads leave the last written data on pwdata.
          if (bus.p_write) begin
            pwdata_d = bus.p_wdata;
          end else begin
            pwdata_d = pwdata_q;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
      end
      ST_ACCESS: begin
        penable_d = 1'b1;
        if (bus.pready) begin
          state_d    = ST_IDLE;
          psel_d     = '0;
          penable_d  = 1'b0;
          p_stable_d = 1'b1;
          if (!pwrite_q) begin
            p_rdata_d = bus.prdata;
          end else begin
            p_rdata_d = p_rdata_q;
          end
        end
`ifdef APB_TIMEOUT_EN
        else if (wait_cnt_q == WAIT_LAST) begin
          // Slave stalled too long: drop the transfer, keep p_rdata.
          state_d   = ST_IDLE;
          psel_d    = '0;
          penable_d = 1'b0;
          p_error_d = 1'b1;
        end else begin
          state_d    = ST_ACCESS;
          wait_cnt_d = wait_cnt_q + {{(WAIT_W-1){1'b0}}, 1'b1};
        end
`else
        else begin
          state_d = ST_ACCESS;
        end
`endif
      end
      default: begin
        state_d   = ST_IDLE;
        psel_d    = '0;
        penable_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      psel_q     <= '0;
      penable_q  <= 1'b0;
      pwrite_q   <= 1'b0;
      paddr_q    <= '0;
      pwdata_q   <= '0;
      p_rdata_q  <= '0;
      p_stable_q <= 1'b0;
      p_error_q  <= 1'b0;
      preset_n_q <= 1'b0;
`ifdef APB_TIMEOUT_EN
      wait_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      psel_q     <= psel_d;
      penable_q  <= penable_d;
      pwrite_q   <= pwrite_d;
      paddr_q    <= paddr_d;
      pwdata_q   <= pwdata_d;
      p_rdata_q  <= p_rdata_d;
      p_stable_q <= p_stable_d;
      p_error_q  <= p_error_d;
      preset_n_q <= 1'b1;
`ifdef APB_TIMEOUT_EN
      wait_cnt_q <= wait_cnt_d;
`endif
    end
  end

  assign bus.psel     = psel_q;
  assign bus.penable  = penable_q;
  assign bus.pwrite   = pwrite_q;
  assign bus.paddr    = paddr_q;
  assign bus.pwdata   = pwdata_q;
  assign bus.p_rdata  = p_rdata_q;
  assign bus.p_stable = p_stable_q;
  assign bus.p_error  = p_error_q;
  assign bus.preset_n = preset_n_q;
  assign bus.state    = state_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// tb_apb_master_ctrl: table-driven cycle vectors for apb_master_ctrl plus
// hand-written sequences for reset during ACCESS and (optionally) timeout.
module tb_apb_master_ctrl;

  logic clk;
  logic reset;
  int   checks;
  int   fails;

  apb_master_ctrl_if #(.ADDR_W(8), .DATA_W(8), .SEL_W(2)) bus_if ();

  apb_master_ctrl #(.ADDR_W(8), .DATA_W(8), .SEL_W(2), .MAX_WAIT(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic [1:0] psel;
    logic       pen;
    logic       pwr;
    logic [7:0] paddr;
    logic [7:0] pwdata;
    logic [7:0] prd;
    logic       stb;
    logic       err;
  } exp_t;

  typedef struct packed {
    logic       start;
    logic       wr;
    logic [1:0] sel;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       rdy;
    exp_t       e;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic s, logic w, logic [1:0] sl, logic [7:0] a,
                              logic [7:0] wd, logic [7:0] rd, logic r,
                              logic [2:0] st, logic [1:0] ps, logic pe, logic pw,
                              logic [7:0] pa, logic [7:0] pwd, logic [7:0] prd,
                              logic stb);
    vec_t v;
    v.start = s;  v.wr = w;  v.sel = sl;  v.addr = a;
    v.wdata = wd; v.rdata = rd; v.rdy = r;
    v.e.st = st;  v.e.psel = ps; v.e.pen = pe; v.e.pwr = pw;
    v.e.paddr = pa; v.e.pwdata = pwd; v.e.prd = prd; v.e.stb = stb;
    v.e.err = 1'b0;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus_if.p_start = v.start;
    bus_if.p_write = v.wr;
    bus_if.p_sel   = v.sel;
    bus_if.p_addr  = v.addr;
    bus_if.p_wdata = v.wdata;
    bus_if.prdata  = v.rdata;
    bus_if.pready  = v.rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input exp_t e);
    exp_t got;
    got.st = bus_if.state; got.psel = bus_if.psel; got.pen = bus_if.penable;
    got.pwr = bus_if.pwrite; got.paddr = bus_if.paddr; got.pwdata = bus_if.pwdata;
    got.prd = bus_if.p_rdata; got.stb = bus_if.p_stable; got.err = bus_if.p_error;
    checks++;
    if (got !== e) begin
      fails++;
      $display("FAIL %s: got st=%0d psel=%0d pen=%0b pwr=%0b paddr=%h pwdata=%h prd=%h stb=%0b err=%0b, required st=%0d psel=%0d pen=%0b pwr=%0b paddr=%h pwdata=%h prd=%h stb=%0b err=%0b",
               tag, got.st, got.psel, got.pen, got.pwr, got.paddr, got.pwdata, got.prd, got.stb, got.err,
               e.st, e.psel, e.pen, e.pwr, e.paddr, e.pwdata, e.prd, e.stb, e.err);
    end
  endtask

  task automatic check_bit(input string tag, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0b, required %0b", tag, got, exp);
    end
  endtask

  initial begin
    vec_t idle_v;
    exp_t e;
    checks = 0;
    fails  = 0;

    // Zero-wait write: inputs scrambled after the latch must not matter.
    vecs.push_back(mk(1,1,2'd1,8'h03,8'h05,8'h00,1, 3'd1,2'd1,0,1,8'h03,8'h05,8'h00,0));
    vecs.push_back(mk(0,0,2'd2,8'hAA,8'h11,8'h00,1, 3'd2,2'd1,1,1,8'h03,8'h05,8'h00,0));
    vecs.push_back(mk(0,0,2'd2,8'hAA,8'h11,8'h00,1, 3'd0,2'd0,0,1,8'h03,8'h05,8'h00,1));
    vecs.push_back(mk(0,0,2'd0,8'h00,8'h00,8'h00,1, 3'd0,2'd0,0,1,8'h03,8'h05,8'h00,0));
    // Zero-wait read of address 6 returning 5; pwdata keeps 5 from the write.
    vecs.push_back(mk(1,0,2'd2,8'h06,8'h99,8'h00,1, 3'd1,2'd2,0,0,8'h06,8'h05,8'h00,0));
    vecs.push_back(mk(0,0,2'd0,8'h00,8'h00,8'h05,1, 3'd2,2'd2,1,0,8'h06,8'h05,8'h00,0));
    vecs.push_back(mk(0,0,2'd0,8'h00,8'h00,8'h05,1, 3'd0,2'd0,0,0,8'h06,8'h05,8'h05,1));
    // 5-wait write, p_start during the waits is ignored.
    vecs.push_back(mk(1,1,2'd1,8'h05,8'h04,8'h00,0, 3'd1,2'd1,0,1,8'h05,8'h04,8'h05,0));
    vecs.push_back(mk(0,1,2'd1,8'h05,8'h04,8'h00,0, 3'd2,2'd1,1,1,8'h05,8'h04,8'h05,0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(1,0,2'd3,8'hFF,8'hEE,8'h00,0, 3'd2,2'd1,1,1,8'h05,8'h04,8'h05,0));
    vecs.push_back(mk(0,0,2'd0,8'h00,8'h00,8'h00,1, 3'd0,2'd0,0,1,8'h05,8'h04,8'h05,1));
    // 5-wait read returning 6; junk prdata during waits must not be captured.
    vecs.push_back(mk(1,0,2'd3,8'h05,8'h00,8'h00,0, 3'd1,2'd3,0,0,8'h05,8'h04,8'h05,0));
    vecs.push_back(mk(0,0,2'd0,8'h00,8'h00,8'h00,0, 3'd2,2'd3,1,0,8'h05,8'h04,8'h05,0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0,0,2'd0,8'h00,8'h00,8'h33,0, 3'd2,2'd3,1,0,8'h05,8'h04,8'h05,0));
    vecs.push_back(mk(0,0,2'd0,8'h00,8'h00,8'h06,1, 3'd0,2'd0,0,0,8'h05,8'h04,8'h06,1));
    // 1-wait write then back-to-back 1-wait read returning 7.
    vecs.push_back(mk(1,1,2'd1,8'h04,8'h03,8'h00,0, 3'd1,2'd1,0,1,8'h04,8'h03,8'h06,0));
    vecs.push_back(mk(0,0,2'd0,8'h00,8'h00,8'h00,0, 3'd2,2'd1,1,1,8'h04,8'h03,8'h06,0));
    vecs.push_back(mk(0,0,2'd0,8'h00,8'h00,8'h00,0, 3'd2,2'd1,1,1,8'h04,8'h03,8'h06,0));
    vecs.push_back(mk(0,0,2'd0,8'h00,8'h00,8'h00,1, 3'd0,2'd0,0,1,8'h04,8'h03,8'h06,1));
    vecs.push_back(mk(1,0,2'd1,8'h04,8'h00,8'h00,0, 3'd1,2'd1,0,0,8'h04,8'h03,8'h06,0));
    vecs.push_back(mk(0,0,2'd0,8'h00,8'h00,8'h00,0, 3'd2,2'd1,1,0,8'h04,8'h03,8'h06,0));
    vecs.push_back(mk(0,0,2'd0,8'h00,8'h00,8'h07,0, 3'd2,2'd1,1,0,8'h04,8'h03,8'h06,0));
    vecs.push_back(mk(0,0,2'd0,8'h00,8'h00,8'h07,1, 3'd0,2'd0,0,0,8'h04,8'h03,8'h07,1));
    // p_start with p_sel==0: no transfer.
    vecs.push_back(mk(1,1,2'd0,8'h77,8'h88,8'h00,1, 3'd0,2'd0,0,0,8'h04,8'h03,8'h07,0));
    vecs.push_back(mk(0,0,2'd0,8'h00,8'h00,8'h00,1, 3'd0,2'd0,0,0,8'h04,8'h03,8'h07,0));

    // Reset state.
    idle_v = mk(0,0,2'd0,8'h00,8'h00,8'h00,0, 3'd0,2'd0,0,0,8'h00,8'h00,8'h00,0);
    drive(idle_v);
    reset = 1'b0;
    tick();
    tick();
    check_out("reset_state", idle_v.e);
    check_bit("reset_preset_n_low", bus_if.preset_n, 1'b0);
    reset = 1'b1;
    tick();
    check_bit("preset_n_release", bus_if.preset_n, 1'b1);
    check_out("idle_after_reset", idle_v.e);

    // Table vectors.
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      tick();
      check_out($sformatf("vec%0d", i), vecs[i].e);
    end

    // Reset asserted while in ACCESS aborts without p_stable.
    drive(mk(1,1,2'd2,8'h09,8'h42,8'h00,0, 3'd0,2'd0,0,0,8'h00,8'h00,8'h00,0));
    tick();
    drive(mk(0,0,2'd0,8'h00,8'h00,8'h00,0, 3'd0,2'd0,0,0,8'h00,8'h00,8'h00,0));
    tick();
    e = '{st:3'd2, psel:2'd2, pen:1'b1, pwr:1'b1, paddr:8'h09, pwdata:8'h42,
          prd:8'h07, stb:1'b0, err:1'b0};
    check_out("rst_pre_access", e);
    reset = 1'b0;
    bus_if.pready = 1'b1;
    tick();
    check_out("rst_in_access", idle_v.e);
    check_bit("rst_in_access_preset_n", bus_if.preset_n, 1'b0);
    reset = 1'b1;
    tick();
    check_out("rst_no_stable", idle_v.e);
    check_bit("rst_release_preset_n", bus_if.preset_n, 1'b1);

`ifdef APB_TIMEOUT_EN
    // pready stuck low: abort after 16 wait cycles with a p_error pulse.
    drive(mk(1,0,2'd1,8'h21,8'h00,8'h00,0, 3'd0,2'd0,0,0,8'h00,8'h00,8'h00,0));
    tick();
    drive(mk(0,0,2'd0,8'h00,8'h00,8'h5A,0, 3'd0,2'd0,0,0,8'h00,8'h00,8'h00,0));
    tick();
    for (int i = 0; i < 15; i++) tick();
    e = '{st:3'd2, psel:2'd1, pen:1'b1, pwr:1'b0, paddr:8'h21, pwdata:8'h00,
          prd:8'h00, stb:1'b0, err:1'b0};
    check_out("timeout_wait15", e);
    tick();
    e = '{st:3'd0, psel:2'd0, pen:1'b0, pwr:1'b0, paddr:8'h21, pwdata:8'h00,
          prd:8'h00, stb:1'b0, err:1'b1};
    check_out("timeout_abort", e);
    tick();
    e.err = 1'b0;
    check_out("timeout_err_pulse", e);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
